// File: rtl/frame_rx_sequencer_pkg.sv
// ============================================================================
// Module      : frame_rx_sequencer_pkg
// Description : Shared types and constants for the frame receive sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_rx_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_PIX_R = 3'd2,
    ST_PIX_G = 3'd3,
    ST_PIX_B = 3'd4,
    ST_FLUSH = 3'd5
  } state_t;

  localparam int HDR_BYTES = 4;

  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  localparam int PIX_ENTRY_W = 24 + 16 + 16 + 3;

  typedef struct packed {
    logic [23:0] data;
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  // Weights sum to 256, so the 16-bit sum never overflows.
  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [15:0] sum;
    sum = 16'(LUMA_R) * 16'(r) + 16'(LUMA_G) * 16'(g) + 16'(LUMA_B) * 16'(b);
    return sum[15:8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_rx_sequencer_if.sv
// ============================================================================
// Module      : frame_rx_sequencer_if
// Description : Byte-in / pixel-out bundle of the frame receive sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_rx_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        abort;
  logic [23:0] pix_data;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic        frame_done;
  logic        err_hdr;
  logic        err_ovf;

  modport slave (
    input  rx_data, rx_valid, abort, pix_ready,
    output pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof, pix_valid,
           busy, frame_done, err_hdr, err_ovf
  );

  modport master (
    output rx_data, rx_valid, abort, pix_ready,
    input  pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof, pix_valid,
           busy, frame_done, err_hdr, err_ovf
  );
endinterface

`default_nettype wire

// File: rtl/frame_rx_sequencer_pix_fifo.sv
// ============================================================================
// Module      : frame_rx_sequencer_pix_fifo
// Description : Synchronous pixel FIFO with registered head and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_rx_sequencer_pix_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 59
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int             c_aw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0]  c_depth   = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0]  c_cnt_one = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == c_depth);
  assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/frame_rx_sequencer.sv
// ============================================================================
// Module      : frame_rx_sequencer
// Description : Parses a W/H header from the UART byte stream, packs RGB bytes
//               into tagged pixels and buffers them for the filter front end.
//               Define GRAY_CONV_EN to emit {Y,Y,Y} luma instead of raw RGB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_rx_sequencer
  import frame_rx_sequencer_pkg::*;
#(
  parameter int MAX_W      = 768,
  parameter int MAX_H      = 512,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  frame_rx_sequencer_if.slave  bus
);

  localparam logic [15:0] c_max_w    = 16'(MAX_W);
  localparam logic [15:0] c_max_h    = 16'(MAX_H);
  localparam logic [1:0]  c_hdr_last = 2'(HDR_BYTES - 1);

  state_t      r_state;
  logic [1:0]  r_hdr_cnt;
  logic [15:0] r_width;
  logic [15:0] r_height;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [7:0]  r_r;
  logic [7:0]  r_g;
  logic        r_err_hdr;
  logic        r_err_ovf;

  logic [15:0] w_hdr_h;
  logic        w_hdr_bad;
  logic        w_last_x;
  logic        w_last_y;
  logic [23:0] w_pix_data;
  pix_t        w_entry;
  pix_t        w_head;
  pix_t        w_head_out;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_ovf;
  logic        w_frame_done;

  assign w_hdr_h   = {r_height[15:8], bus.rx_data};
  assign w_hdr_bad = (r_width == 16'd0) || (r_width > c_max_w) ||
                     (w_hdr_h == 16'd0) || (w_hdr_h > c_max_h);
  assign w_last_x  = (r_x == r_width - 16'd1);
  assign w_last_y  = (r_y == r_height - 16'd1);

`ifdef GRAY_CONV_EN
  assign w_pix_data = {3{luma(r_r, r_g, bus.rx_data)}};
`else
  assign w_pix_data = {r_r, r_g, bus.rx_data};
`endif

  always_comb begin
    w_entry      = '0;
    w_entry.data = w_pix_data;
    w_entry.x    = r_x;
    w_entry.y    = r_y;
    w_entry.sof  = (r_x == 16'd0) && (r_y == 16'd0);
    w_entry.eol  = w_last_x;
    w_entry.eof  = w_last_x && w_last_y;
  end

  assign w_push       = (r_state == ST_PIX_B) && bus.rx_valid && !bus.abort;
  assign w_accept     = !w_empty && bus.pix_ready;
  assign w_ovf        = w_push && w_full && !w_accept;
  assign w_frame_done = (r_state == ST_FLUSH) && w_accept && w_head.eof && !bus.abort;

  frame_rx_sequencer_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_ENTRY_W)
  ) u_pix_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (bus.abort),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (bus.pix_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_hdr_cnt <= '0;
      r_width   <= '0;
      r_height  <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_r       <= '0;
      r_g       <= '0;
      r_err_hdr <= 1'b0;
      r_err_ovf <= 1'b0;
    end else if (bus.abort) begin
      r_state   <= ST_IDLE;
      r_hdr_cnt <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            r_width[15:8] <= bus.rx_data;
            r_hdr_cnt     <= 2'd1;
            r_state       <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (bus.rx_valid) begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            if (r_hdr_cnt == 2'd1) begin
              r_width[7:0] <= bus.rx_data;
            end else if (r_hdr_cnt == 2'd2) begin
              r_height[15:8] <= bus.rx_data;
            end else if (r_hdr_cnt == c_hdr_last) begin
              r_hdr_cnt <= '0;
              r_height  <= w_hdr_h;
              r_x       <= '0;
              r_y       <= '0;
              if (w_hdr_bad) begin
                r_err_hdr <= 1'b1;
                r_state   <= ST_IDLE;
              end else begin
                r_state   <= ST_PIX_R;
              end
            end
          end
        end
        ST_PIX_R: begin
          if (bus.rx_valid) begin
            r_r     <= bus.rx_data;
            r_state <= ST_PIX_G;
          end
        end
        ST_PIX_G: begin
          if (bus.rx_valid) begin
            r_g     <= bus.rx_data;
            r_state <= ST_PIX_B;
          end
        end
        ST_PIX_B: begin
          if (bus.rx_valid) begin
            if (w_ovf) r_err_ovf <= 1'b1;
            // Coordinates advance even for a dropped pixel so geometry stays intact.
            if (w_last_x) begin
              r_x <= '0;
              r_y <= w_last_y ? 16'd0 : r_y + 16'd1;
            end else begin
              r_x <= r_x + 16'd1;
            end
            r_state <= (w_last_x && w_last_y) ? ST_FLUSH : ST_PIX_R;
          end
        end
        ST_FLUSH: begin
          // An empty FIFO here means the EOF pixel was dropped; nothing left to wait for.
          if (w_frame_done || w_empty) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_head_out = w_empty ? '0 : w_head;

  assign bus.pix_data   = w_head_out.data;
  assign bus.pix_x      = w_head_out.x;
  assign bus.pix_y      = w_head_out.y;
  assign bus.pix_sof    = w_head_out.sof;
  assign bus.pix_eol    = w_head_out.eol;
  assign bus.pix_eof    = w_head_out.eof;
  assign bus.pix_valid  = !w_empty;
  assign bus.busy       = (r_state != ST_IDLE) || !w_empty;
  assign bus.frame_done = w_frame_done;
  assign bus.err_hdr    = r_err_hdr;
  assign bus.err_ovf    = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_frame_rx_sequencer.sv
// ============================================================================
// Module      : tb_frame_rx_sequencer
// Description : Directed self-checking bench for frame_rx_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_rx_sequencer;

  typedef struct packed {
    logic [23:0] d;
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
  } cap_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  cap_t cap_q[$];

  frame_rx_sequencer_if bus();

  frame_rx_sequencer #(
    .MAX_W      (768),
    .MAX_H      (512),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge view matches the next posedge.
  always @(negedge clk) begin
    if (reset && bus.pix_valid && bus.pix_ready)
      cap_q.push_back({bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol, bus.pix_eof});
    if (bus.frame_done) done_cnt++;
  end

  function automatic logic [23:0] exp_pix(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
`ifdef GRAY_CONV_EN
    int s;
    logic [7:0] y;
    s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
    y = 8'(s >> 8);
    return {y, y, y};
`else
    return {r, g, b};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] w, input logic [15:0] h);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    send_byte(h[15:8]);
    send_byte(h[7:0]);
  endtask

  task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    send_byte(r);
    send_byte(g);
    send_byte(b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && bus.busy; i++) tick(1);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.abort = 1'b0; bus.pix_ready = 1'b0;
    reset = 1'b0;
    tick(3);
    checks++;
    if ({bus.pix_valid, bus.busy, bus.frame_done, bus.err_hdr, bus.err_ovf} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {bus.pix_valid, bus.busy, bus.frame_done, bus.err_hdr, bus.err_ovf});
    end
    checks++;
    if ({bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol, bus.pix_eof} !== '0) begin
      errors++;
      $display("FAIL reset_pix: got data=%h x=%0d y=%0d, expected zeros",
               bus.pix_data, bus.pix_x, bus.pix_y);
    end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_frame_4x2();
    int   b0, d0;
    cap_t e, g;
    bus.pix_ready = 1'b1;
    b0 = cap_q.size();
    d0 = done_cnt;
    send_hdr(16'd4, 16'd2);
    for (int i = 0; i < 8; i++) send_pix(8'(16 * i + 1), 8'(16 * i + 2), 8'(16 * i + 3));
    wait_idle();
    checks++;
    if (cap_q.size() - b0 != 8) begin
      errors++;
      $display("FAIL f4x2_count: got %0d pixels, expected 8", cap_q.size() - b0);
    end
    for (int i = 0; i < 8; i++) begin
      g = (b0 + i < cap_q.size()) ? cap_q[b0 + i] : '0;
      e.d = exp_pix(8'(16 * i + 1), 8'(16 * i + 2), 8'(16 * i + 3));
      e.x = 16'(i % 4);
      e.y = 16'(i / 4);
      e.sof = (i == 0);
      e.eol = (i % 4 == 3);
      e.eof = (i == 7);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL f4x2_pix%0d: got %h, expected %h", i, g, e);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL f4x2_done: got %0d frame_done pulses, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_bad_header();
    int   b0, d0;
    cap_t e, g;
    bus.pix_ready = 1'b1;
    send_hdr(16'd0, 16'd2);
    tick(1);
    checks++;
    if ({bus.err_hdr, bus.busy, bus.pix_valid} !== 3'b100) begin
      errors++;
      $display("FAIL bad_hdr: got err/busy/valid=%b, expected 100",
               {bus.err_hdr, bus.busy, bus.pix_valid});
    end
    b0 = cap_q.size();
    d0 = done_cnt;
    send_hdr(16'd1, 16'd1);
    send_pix(8'hFF, 8'h00, 8'h00);
    wait_idle();
`ifdef GRAY_CONV_EN
    e.d = 24'h4C4C4C;
`else
    e.d = 24'hFF0000;
`endif
    e.x = 16'd0; e.y = 16'd0; e.sof = 1'b1; e.eol = 1'b1; e.eof = 1'b1;
    g = (cap_q.size() == b0 + 1) ? cap_q[b0] : '0;
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL one_by_one: got %h (n=%0d), expected %h", g, cap_q.size() - b0, e);
    end
    checks++;
    if (done_cnt - d0 != 1 || bus.err_hdr !== 1'b1) begin
      errors++;
      $display("FAIL one_by_one_done: got done=%0d err_hdr=%b, expected 1 1",
               done_cnt - d0, bus.err_hdr);
    end
  endtask

  task automatic test_hdr_limits();
    do_reset();
    send_hdr(16'd768, 16'd512);
    checks++;
    if ({bus.busy, bus.err_hdr} !== 2'b10) begin
      errors++;
      $display("FAIL hdr_max_ok: got busy/err=%b, expected 10", {bus.busy, bus.err_hdr});
    end
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    send_hdr(16'd1, 16'd513);
    checks++;
    if ({bus.busy, bus.err_hdr} !== 2'b01) begin
      errors++;
      $display("FAIL hdr_h_over: got busy/err=%b, expected 01", {bus.busy, bus.err_hdr});
    end
    do_reset();
    send_hdr(16'd769, 16'd1);
    checks++;
    if ({bus.busy, bus.err_hdr} !== 2'b01) begin
      errors++;
      $display("FAIL hdr_w_over: got busy/err=%b, expected 01", {bus.busy, bus.err_hdr});
    end
  endtask

  task automatic test_full_pop_push();
    int   b0, d0;
    cap_t e, g;
    bus.pix_ready = 1'b0;
    b0 = cap_q.size();
    d0 = done_cnt;
    send_hdr(16'd5, 16'd1);
    for (int i = 0; i < 4; i++) send_pix(8'(i), 8'(i + 8), 8'(i + 16));
    send_byte(8'd4);
    send_byte(8'd12);
    bus.rx_data = 8'd20; bus.rx_valid = 1'b1; bus.pix_ready = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0; bus.pix_ready = 1'b0;
    checks++;
    if (bus.err_ovf !== 1'b0 || bus.pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_push: got err_ovf=%b valid=%b, expected 0 1",
               bus.err_ovf, bus.pix_valid);
    end
    bus.pix_ready = 1'b1;
    wait_idle();
    g = (cap_q.size() == b0 + 5) ? cap_q[b0 + 4] : '0;
    e.d = exp_pix(8'd4, 8'd12, 8'd20);
    e.x = 16'd4; e.y = 16'd0; e.sof = 1'b0; e.eol = 1'b1; e.eof = 1'b1;
    checks++;
    if (g !== e || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL full_pop_push_last: got %h (n=%0d done=%0d), expected %h with 5 pixels 1 done",
               g, cap_q.size() - b0, done_cnt - d0, e);
    end
  endtask

  task automatic test_overflow();
    int   b0, d0;
    cap_t e, g;
    bus.pix_ready = 1'b0;
    send_hdr(16'd2, 16'd2);
    for (int i = 0; i < 4; i++) send_pix(8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i));
    tick(3);
    checks++;
    if ({bus.pix_valid, bus.busy, bus.err_ovf} !== 3'b110) begin
      errors++;
      $display("FAIL hold_flags: got valid/busy/ovf=%b, expected 110",
               {bus.pix_valid, bus.busy, bus.err_ovf});
    end
    checks++;
    if ({bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof} !==
        {exp_pix(8'hA0, 8'hB0, 8'hC0), 16'd0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL hold_head: got data=%h x=%0d y=%0d sof=%b, expected pixel 0 of frame",
               bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof);
    end
    b0 = cap_q.size();
    d0 = done_cnt;
    bus.pix_ready = 1'b1;
    wait_idle();
    checks++;
    if (cap_q.size() - b0 != 4 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL hold_drain: got %0d pixels %0d done, expected 4 1",
               cap_q.size() - b0, done_cnt - d0);
    end
    bus.pix_ready = 1'b0;
    send_hdr(16'd3, 16'd2);
    for (int i = 0; i < 6; i++) send_pix(8'h10 * 8'(i), 8'h01, 8'h02);
    tick(1);
    checks++;
    if (bus.err_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got err_ovf=%b, expected 1", bus.err_ovf);
    end
    b0 = cap_q.size();
    d0 = done_cnt;
    bus.pix_ready = 1'b1;
    tick(8);
    g = (cap_q.size() == b0 + 4) ? cap_q[b0 + 3] : '0;
    e.d = exp_pix(8'h30, 8'h01, 8'h02);
    e.x = 16'd0; e.y = 16'd1; e.sof = 1'b0; e.eol = 1'b0; e.eof = 1'b0;
    checks++;
    if (g !== e || done_cnt - d0 != 0) begin
      errors++;
      $display("FAIL ovf_kept: got %h (n=%0d done=%0d), expected %h with 4 pixels 0 done",
               g, cap_q.size() - b0, done_cnt - d0, e);
    end
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
  endtask

  task automatic test_abort();
    int d0;
    bus.pix_ready = 1'b0;
    d0 = done_cnt;
    send_hdr(16'd4, 16'd2);
    send_pix(8'h11, 8'h22, 8'h33);
    send_pix(8'h44, 8'h55, 8'h66);
    tick(1);
    checks++;
    if ({bus.pix_valid, bus.busy} !== 2'b11) begin
      errors++;
      $display("FAIL abort_pre: got valid/busy=%b, expected 11", {bus.pix_valid, bus.busy});
    end
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    checks++;
    if ({bus.pix_valid, bus.busy, bus.err_ovf} !== 3'b001) begin
      errors++;
      $display("FAIL abort_post: got valid/busy/ovf=%b, expected 001",
               {bus.pix_valid, bus.busy, bus.err_ovf});
    end
    tick(3);
    checks++;
    if (done_cnt - d0 != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got done=%0d busy=%b, expected 0 0", done_cnt - d0, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    bus.pix_ready = 1'b0;
    send_hdr(16'd2, 16'd2);
    send_pix(8'h01, 8'h02, 8'h03);
    tick(1);
    checks++;
    if ({bus.pix_valid, bus.err_hdr, bus.err_ovf} !== 3'b111) begin
      errors++;
      $display("FAIL areset_pre: got valid/hdr/ovf=%b, expected 111",
               {bus.pix_valid, bus.err_hdr, bus.err_ovf});
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.pix_valid, bus.busy, bus.frame_done, bus.err_hdr, bus.err_ovf} !== 5'b0 ||
        bus.pix_data !== 24'h0) begin
      errors++;
      $display("FAIL areset_now: got flags=%b data=%h, expected 00000 000000",
               {bus.pix_valid, bus.busy, bus.frame_done, bus.err_hdr, bus.err_ovf}, bus.pix_data);
    end
    tick(1);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_frame_4x2();
    test_bad_header();
    test_hdr_limits();
    test_full_pop_push();
    test_overflow();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
